// File: rtl/axi_pkg.sv
// Minimal AXI4 types and response codes shared by the protection-unit blocks.
package axi_pkg;

    typedef logic [7:0] len_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/pu_pkg.sv
// Types for the deny responder: FSM states, default deny response, log record
// (the log record is only used when PU_DENY_LOG_EN is defined).
package pu_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DRAIN = 2'd1,
        W_RESP  = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_t;

    localparam logic [1:0] DENY_RESP_DEFAULT = axi_pkg::RESP_DECERR;

    // Log fields are sized for the widest supported bus; unused upper bits stay zero.
    localparam int LOG_ADDR_MAX = 64;
    localparam int LOG_ID_MAX   = 32;

    typedef struct packed {
        logic [31:0]             count;
        logic [LOG_ADDR_MAX-1:0] addr;
        logic [LOG_ID_MAX-1:0]   id;
        logic                    write;
    } deny_log_t;

    function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'd0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/pu_deny_log.sv
// Denied-transaction log: saturating handshake counter plus capture of the
// most recent denied address/ID/direction (write wins on a tie).
module pu_deny_log
    import pu_pkg::*;
#(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aw_hs,
    input  logic                  ar_hs,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ID_WIDTH-1:0]   ar_id,
    output deny_log_t             log_state
);

    logic [31:0]           count_r, count_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [ID_WIDTH-1:0]   id_r, id_s;
    logic                  write_r, write_s;

    // Next log contents from this cycle's handshakes.
    always_comb begin
        count_s = sat_add(count_r, {1'b0, aw_hs} + {1'b0, ar_hs});
        addr_s  = addr_r;
        id_s    = id_r;
        write_s = write_r;
        if (aw_hs) begin
            addr_s  = aw_addr;
            id_s    = aw_id;
            write_s = 1'b1;
        end else if (ar_hs) begin
            addr_s  = ar_addr;
            id_s    = ar_id;
            write_s = 1'b0;
        end else begin
            write_s = write_r;
        end
    end

    // Log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            id_r    <= {ID_WIDTH{1'b0}};
            write_r <= 1'b0;
        end else begin
            count_r <= count_s;
            addr_r  <= addr_s;
            id_r    <= id_s;
            write_r <= write_s;
        end
    end

    // Pack registered fields into the zero-extended log record.
    always_comb begin
        log_state                  = '0;
        log_state.count            = count_r;
        log_state.addr[ADDR_WIDTH-1:0] = addr_r;
        log_state.id[ID_WIDTH-1:0] = id_r;
        log_state.write            = write_r;
    end

endmodule

// File: rtl/pu_deny_responder.sv
// AXI4 terminating responder for denied transactions: drains writes and returns
// one error B, answers reads with LEN+1 error beats. Optional log: PU_DENY_LOG_EN.
module pu_deny_responder
    import pu_pkg::*;
#(
    parameter int         ID_WIDTH   = 16,
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 64,
    parameter logic [1:0] DENY_RESP  = DENY_RESP_DEFAULT
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [ID_WIDTH-1:0]   S_AWID,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    input  logic                  S_WLAST,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    output logic [ID_WIDTH-1:0]   S_BID,
    output logic [1:0]            S_BRESP,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    input  logic [ID_WIDTH-1:0]   S_ARID,
    input  axi_pkg::len_t         S_ARLEN,
    output logic                  S_RVALID,
    input  logic                  S_RREADY,
    output logic [ID_WIDTH-1:0]   S_RID,
    output logic [DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0]            S_RRESP,
`ifdef PU_DENY_LOG_EN
    input  logic [ADDR_WIDTH-1:0] S_AWADDR,
    input  logic [ADDR_WIDTH-1:0] S_ARADDR,
    output logic [31:0]           DENY_COUNT,
    output logic [ADDR_WIDTH-1:0] LAST_DENY_ADDR,
    output logic [ID_WIDTH-1:0]   LAST_DENY_ID,
    output logic                  LAST_DENY_WRITE,
`endif
    output logic                  S_RLAST
);

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > LOG_ADDR_MAX || ID_WIDTH < 1 || ID_WIDTH > LOG_ID_MAX) begin : g_bad_width
        $error("pu_deny_responder: unsupported ADDR_WIDTH/ID_WIDTH");
    end

    w_state_t            w_state_r, w_state_s;
    logic [ID_WIDTH-1:0] bid_r, bid_s;
    logic                awready_r, wready_r, bvalid_r;
    r_state_t            r_state_r, r_state_s;
    logic [ID_WIDTH-1:0] rid_r, rid_s;
    axi_pkg::len_t       r_len_r, r_len_s, r_cnt_r, r_cnt_s;
    logic                arready_r, rvalid_r, rlast_r;
    logic                aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    assign aw_hs_s = S_AWVALID & awready_r;
    assign w_hs_s  = S_WVALID & wready_r;
    assign b_hs_s  = bvalid_r & S_BREADY;
    assign ar_hs_s = S_ARVALID & arready_r;
    assign r_hs_s  = rvalid_r & S_RREADY;

    // Write FSM next state and ID capture.
    always_comb begin
        w_state_s = w_state_r;
        bid_s     = bid_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    w_state_s = W_DRAIN;
                    bid_s     = S_AWID;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DRAIN: begin
                if (w_hs_s && S_WLAST) begin
                    w_state_s = W_RESP;
                end else begin
                    w_state_s = W_DRAIN;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Read FSM next state, ID/LEN capture and beat counter.
    always_comb begin
        r_state_s = r_state_r;
        rid_s     = rid_r;
        r_len_s   = r_len_r;
        r_cnt_s   = r_cnt_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_s = R_BURST;
                    rid_s     = S_ARID;
                    r_len_s   = S_ARLEN;
                    r_cnt_s   = 8'd0;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_BURST: begin
                if (r_hs_s && rlast_r) begin
                    r_state_s = R_IDLE;
                end else if (r_hs_s) begin
                    r_cnt_s = r_cnt_r + 8'd1;
                end else begin
                    r_state_s = R_BURST;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // State and handshake-output registers; outputs are decoded from the next state
    // so READY/VALID/RLAST come straight from flops.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_r <= W_IDLE;
            bid_r     <= {ID_WIDTH{1'b0}};
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            r_state_r <= R_IDLE;
            rid_r     <= {ID_WIDTH{1'b0}};
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            bid_r     <= bid_s;
            awready_r <= (w_state_s == W_IDLE);
            wready_r  <= (w_state_s == W_DRAIN);
            bvalid_r  <= (w_state_s == W_RESP);
            r_state_r <= r_state_s;
            rid_r     <= rid_s;
            r_len_r   <= r_len_s;
            r_cnt_r   <= r_cnt_s;
            arready_r <= (r_state_s == R_IDLE);
            rvalid_r  <= (r_state_s == R_BURST);
            rlast_r   <= (r_state_s == R_BURST) && (r_cnt_s == r_len_s);
        end
    end

    assign S_AWREADY = awready_r;
    assign S_WREADY  = wready_r;
    assign S_BVALID  = bvalid_r;
    assign S_BID     = bid_r;
    assign S_BRESP   = DENY_RESP;
    assign S_ARREADY = arready_r;
    assign S_RVALID  = rvalid_r;
    assign S_RID     = rid_r;
    assign S_RDATA   = {DATA_WIDTH{1'b0}};
    assign S_RRESP   = DENY_RESP;
    assign S_RLAST   = rlast_r;

`ifdef PU_DENY_LOG_EN
    deny_log_t log_s;

    pu_deny_log #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_log (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .aw_hs     (aw_hs_s),
        .ar_hs     (ar_hs_s),
        .aw_addr   (S_AWADDR),
        .ar_addr   (S_ARADDR),
        .aw_id     (S_AWID),
        .ar_id     (S_ARID),
        .log_state (log_s)
    );

    assign DENY_COUNT      = log_s.count;
    assign LAST_DENY_ADDR  = log_s.addr[ADDR_WIDTH-1:0];
    assign LAST_DENY_ID    = log_s.id[ID_WIDTH-1:0];
    assign LAST_DENY_WRITE = log_s.write;
`endif

endmodule

// File: tb/tb_pu_deny_responder.sv
// Self-checking bench for pu_deny_responder: directed scenarios plus random
// traffic against a transaction-level model. Log checks run with PU_DENY_LOG_EN.
module tb_pu_deny_responder;

    localparam int IDW = 16;
    localparam int AW  = 32;
    localparam int DW  = 64;

    logic            ACLK, ARESETN;
    logic            S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_WLAST;
    logic            S_BVALID, S_BREADY, S_ARVALID, S_ARREADY;
    logic            S_RVALID, S_RREADY, S_RLAST;
    logic [IDW-1:0]  S_AWID, S_BID, S_ARID, S_RID;
    logic [7:0]      S_ARLEN;
    logic [DW-1:0]   S_RDATA;
    logic [1:0]      S_BRESP, S_RRESP;
`ifdef PU_DENY_LOG_EN
    logic [AW-1:0]   S_AWADDR, S_ARADDR, LAST_DENY_ADDR;
    logic [31:0]     DENY_COUNT;
    logic [IDW-1:0]  LAST_DENY_ID;
    logic            LAST_DENY_WRITE;
`endif

    int checks = 0;
    int errors = 0;

    // Transaction-level model: a write is "active" from AW acceptance until its B
    // is taken; a read has a number of beats still owed to the initiator.
    bit             m_ready_ok;
    bit             m_w_active;
    bit             m_w_last;
    int             m_r_left;
    logic [IDW-1:0] m_bid, m_rid;

    pu_deny_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WLAST(S_WLAST),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID), .S_ARLEN(S_ARLEN),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
        .S_RRESP(S_RRESP),
`ifdef PU_DENY_LOG_EN
        .S_AWADDR(S_AWADDR), .S_ARADDR(S_ARADDR), .DENY_COUNT(DENY_COUNT),
        .LAST_DENY_ADDR(LAST_DENY_ADDR), .LAST_DENY_ID(LAST_DENY_ID),
        .LAST_DENY_WRITE(LAST_DENY_WRITE),
`endif
        .S_RLAST(S_RLAST)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready_ok = 1'b0;
        m_w_active = 1'b0;
        m_w_last   = 1'b0;
        m_r_left   = 0;
        m_bid      = '0;
        m_rid      = '0;
    endtask

    task automatic check_all();
        chk("awready", 64'(S_AWREADY), 64'(m_ready_ok && !m_w_active));
        chk("wready",  64'(S_WREADY),  64'(m_w_active && !m_w_last));
        chk("bvalid",  64'(S_BVALID),  64'(m_w_active && m_w_last));
        chk("arready", 64'(S_ARREADY), 64'(m_ready_ok && m_r_left == 0));
        chk("rvalid",  64'(S_RVALID),  64'(m_r_left > 0));
        chk("bid",     64'(S_BID),     64'(m_bid));
        chk("rid",     64'(S_RID),     64'(m_rid));
        chk("rdata",   64'(S_RDATA),   64'd0);
        if (m_r_left > 0) begin
            chk("rlast", 64'(S_RLAST), 64'(m_r_left == 1));
            chk("rresp", 64'(S_RRESP), 64'd3);
        end
        if (m_w_active && m_w_last) begin
            chk("bresp", 64'(S_BRESP), 64'd3);
        end
    endtask

    // One clock: decide handshakes from the model's view, advance, then compare.
    task automatic step();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, wl;
        logic [IDW-1:0] awid, arid;
        logic [7:0] arlen;
        aw_hs = S_AWVALID && m_ready_ok && !m_w_active;
        w_hs  = S_WVALID && m_w_active && !m_w_last;
        b_hs  = S_BREADY && m_w_active && m_w_last;
        ar_hs = S_ARVALID && m_ready_ok && m_r_left == 0;
        r_hs  = S_RREADY && m_r_left > 0;
        wl    = S_WLAST;
        awid  = S_AWID;
        arid  = S_ARID;
        arlen = S_ARLEN;
        @(posedge ACLK);
        #1;
        if (ARESETN) begin
            if (aw_hs) begin
                m_w_active = 1'b1;
                m_w_last   = 1'b0;
                m_bid      = awid;
            end else if (w_hs && wl) begin
                m_w_last = 1'b1;
            end else if (b_hs) begin
                m_w_active = 1'b0;
            end
            if (ar_hs) begin
                m_r_left = int'(arlen) + 1;
                m_rid    = arid;
            end else if (r_hs) begin
                m_r_left = m_r_left - 1;
            end
            m_ready_ok = 1'b1;
        end
        check_all();
    endtask

    task automatic idle_inputs();
        S_AWVALID = 1'b0; S_AWID = '0; S_WVALID = 1'b0; S_WLAST = 1'b0; S_BREADY = 1'b0;
        S_ARVALID = 1'b0; S_ARID = '0; S_ARLEN = 8'd0; S_RREADY = 1'b0;
`ifdef PU_DENY_LOG_EN
        S_AWADDR = '0; S_ARADDR = '0;
`endif
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        idle_inputs();
        @(posedge ACLK);
        #1;
        model_reset();
        check_all();
        chk("rst_rlast", 64'(S_RLAST), 64'd0);
`ifdef PU_DENY_LOG_EN
        chk("rst_count", 64'(DENY_COUNT), 64'd0);
        chk("rst_laddr", 64'(LAST_DENY_ADDR), 64'd0);
        chk("rst_lid",   64'(LAST_DENY_ID), 64'd0);
        chk("rst_lwr",   64'(LAST_DENY_WRITE), 64'd0);
`endif
        @(negedge ACLK);
        ARESETN = 1'b1;
        step();
        chk("rst_arready_rise", 64'(S_ARREADY), 64'd1);
    endtask

    initial begin
        int nw;
        ARESETN = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();

        // Write: ID 0x12, four beats, WLAST on the fourth.
        S_AWVALID = 1'b1; S_AWID = 16'h0012;
        step();
        S_AWVALID = 1'b0;
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            S_WVALID = 1'b1;
            S_WLAST  = (i == 3);
            nw += int'(S_WVALID && S_WREADY);
            step();
        end
        S_WVALID = 1'b0; S_WLAST = 1'b0;
        chk("t1_wbeats", 64'(nw), 64'd4);
        chk("t1_bvalid", 64'(S_BVALID), 64'd1);
        chk("t1_bid",    64'(S_BID), 64'h12);
        chk("t1_bresp",  64'(S_BRESP), 64'd3);
        S_BREADY = 1'b1;
        step();
        S_BREADY = 1'b0;
        chk("t1_awready_after_b", 64'(S_AWREADY), 64'd1);

        // Read: ID 0x07, LEN 3, RREADY held.
        S_ARVALID = 1'b1; S_ARID = 16'h0007; S_ARLEN = 8'd3;
        step();
        S_ARVALID = 1'b0; S_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_rvalid", 64'(S_RVALID), 64'd1);
            chk("t2_rlast",  64'(S_RLAST), 64'(i == 3));
            chk("t2_rid",    64'(S_RID), 64'h7);
            step();
        end
        chk("t2_arready_after", 64'(S_ARREADY), 64'd1);
        chk("t2_rvalid_after",  64'(S_RVALID), 64'd0);

        // Read LEN 0 with RREADY low for two cycles: single beat held stable.
        S_RREADY = 1'b0; S_ARVALID = 1'b1; S_ARID = 16'h0009; S_ARLEN = 8'd0;
        step();
        S_ARVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t3_rlast_held", 64'(S_RLAST), 64'd1);
        end
        S_RREADY = 1'b1;
        step();
        chk("t3_done", 64'(S_RVALID), 64'd0);

        // Simultaneous AW (ID 1) and AR (ID 2, LEN 1) with BREADY low.
        S_AWVALID = 1'b1; S_AWID = 16'h0001;
        S_ARVALID = 1'b1; S_ARID = 16'h0002; S_ARLEN = 8'd1;
        step();
        S_AWVALID = 1'b0; S_ARVALID = 1'b0;
        S_WVALID = 1'b1; S_WLAST = 1'b1;
        step();
        S_WVALID = 1'b0; S_WLAST = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t4_r_done",    64'(S_RVALID), 64'd0);
        chk("t4_bvalid",    64'(S_BVALID), 64'd1);
        chk("t4_bid",       64'(S_BID), 64'h1);
        S_BREADY = 1'b1;
        step();
        S_BREADY = 1'b0;

        // Reset during beat 2 of an 8-beat read.
        S_ARVALID = 1'b1; S_ARID = 16'h0033; S_ARLEN = 8'd7;
        step();
        S_ARVALID = 1'b0;
        step();
        step();
        ARESETN = 1'b0;
        #1;
        chk("t5_rvalid_async", 64'(S_RVALID), 64'd0);
        chk("t5_arready_async", 64'(S_ARREADY), 64'd0);
        chk("t5_awready_async", 64'(S_AWREADY), 64'd0);
        do_reset();
        S_ARVALID = 1'b1; S_ARID = 16'h0044; S_ARLEN = 8'd2;
        step();
        S_ARVALID = 1'b0; S_RREADY = 1'b1;
        chk("t5_new_beat0_rlast", 64'(S_RLAST), 64'd0);
        for (int i = 0; i < 3; i++) step();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            S_AWVALID = 1'($urandom_range(0, 1));
            S_AWID    = 16'($urandom);
            S_WVALID  = 1'($urandom_range(0, 1));
            S_WLAST   = ($urandom_range(0, 3) == 0);
            S_BREADY  = 1'($urandom_range(0, 1));
            S_ARVALID = 1'($urandom_range(0, 1));
            S_ARID    = 16'($urandom);
            S_ARLEN   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            S_RREADY  = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef PU_DENY_LOG_EN
        do_reset();
        S_ARVALID = 1'b1; S_ARID = 16'h0005; S_ARADDR = 32'h0000_1000; S_ARLEN = 8'd0;
        step();
        S_ARVALID = 1'b0; S_RREADY = 1'b1;
        chk("log_count1", 64'(DENY_COUNT), 64'd1);
        chk("log_wr0",    64'(LAST_DENY_WRITE), 64'd0);
        chk("log_addr_r", 64'(LAST_DENY_ADDR), 64'h1000);
        chk("log_id_r",   64'(LAST_DENY_ID), 64'h5);
        step();
        force dut.u_log.count_r = 32'hFFFF_FFFD;
        #1;
        release dut.u_log.count_r;
        S_AWVALID = 1'b1; S_AWID = 16'h0033; S_AWADDR = 32'h4000_0000;
        S_ARVALID = 1'b1; S_ARID = 16'h0066; S_ARADDR = 32'h0000_2000;
        step();
        S_AWVALID = 1'b0; S_ARVALID = 1'b0;
        chk("log_count_plus2", 64'(DENY_COUNT), 64'hFFFF_FFFF);
        chk("log_wr1",     64'(LAST_DENY_WRITE), 64'd1);
        chk("log_addr_w",  64'(LAST_DENY_ADDR), 64'h4000_0000);
        chk("log_id_w",    64'(LAST_DENY_ID), 64'h33);
        S_WVALID = 1'b1; S_WLAST = 1'b1;
        step();
        S_WVALID = 1'b0; S_WLAST = 1'b0; S_BREADY = 1'b1;
        step();
        S_ARVALID = 1'b1; S_ARADDR = 32'h0000_3000;
        step();
        S_ARVALID = 1'b0;
        chk("log_count_sat", 64'(DENY_COUNT), 64'hFFFF_FFFF);
        chk("log_addr_r2",   64'(LAST_DENY_ADDR), 64'h3000);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_deny_responder.md
# pu_deny_responder

AXI4 terminating responder for transactions the protection unit has refused. When `PolicyCheck` deasserts GRANTED, the protection unit routes the offending request here instead of downstream. This block completes the transaction protocol-correctly toward the initiator:
- Writes: drain all W beats, then return one error B.
- Reads: return LEN+1 error R beats.

Read and write paths are independent, with one outstanding transaction per direction.

## Interface
Parameters:
- ID_WIDTH, 16, AXI ID width (matches PolicyCheck ID).
- ADDR_WIDTH, 32, address width (used only with PU_DENY_LOG_EN).
- DATA_WIDTH, 64, R data width.
- DENY_RESP, axi_pkg::RESP_DECERR, response code driven on BRESP/RRESP.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AWVALID / S_AWREADY  in/out  1  denied write address handshake.
- S_AWID  in  ID_WIDTH  write ID.
- S_WVALID / S_WREADY  in/out  1  write data handshake (data itself ignored).
- S_WLAST  in  1  last write beat.
- S_BVALID / S_BREADY  out/in  1  write response handshake.
- S_BID  out  ID_WIDTH  captured AWID.
- S_BRESP  out  2  DENY_RESP.
- S_ARVALID / S_ARREADY  in/out  1  denied read address handshake.
- S_ARID  in  ID_WIDTH  read ID.
- S_ARLEN  in  axi_pkg::len_t  burst length.
- S_RVALID / S_RREADY  out/in  1  read data handshake.
- S_RID  out  ID_WIDTH  captured ARID.
- S_RDATA  out  DATA_WIDTH  constant zero.
- S_RRESP  out  2  DENY_RESP.
- S_RLAST  out  1  last read beat.
- The following exist only with PU_DENY_LOG_EN:
  - S_AWADDR, S_ARADDR  in  ADDR_WIDTH.
  - DENY_COUNT  out  32.
  - LAST_DENY_ADDR  out  ADDR_WIDTH.
  - LAST_DENY_ID  out  ID_WIDTH.
  - LAST_DENY_WRITE  out  1.

## Operation
Write FSM, states W_IDLE → W_DRAIN → W_RESP → W_IDLE:
- W_IDLE: AWREADY=1. On AW handshake, capture AWID and go to W_DRAIN.
- W_DRAIN: WREADY=1. Each W handshake is consumed. A handshake with WLAST=1 moves to W_RESP. Beats without WLAST keep the state; there is no beat limit.
- W_RESP: BVALID=1, BID=captured ID, BRESP=DENY_RESP. On B handshake go to W_IDLE.
- W beats presented before the AW is accepted are not accepted (WREADY=0 outside W_DRAIN).

Read FSM, states R_IDLE → R_BURST → R_IDLE:
- R_IDLE: ARREADY=1. On AR handshake, capture ARID and ARLEN, clear the beat counter, and go to R_BURST.
- R_BURST: RVALID=1, RDATA=0, RRESP=DENY_RESP, RLAST=(counter==captured LEN).
  - Counter increments on each R handshake.
  - The handshake with RLAST=1 returns to R_IDLE.
- Counter is an 8-bit axi_pkg::len_t; no wrap is possible because the exit happens at the LEN compare. LEN=0 gives a single beat with RLAST=1.

General:
- Both FSMs run concurrently; simultaneous AW and AR acceptance is legal.
- VALID outputs never drop without a handshake; RID/BID/RLAST are stable while VALID is high.

## Timing
- Reset values:
  - AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST = 0; BID, RID = 0.
  - FSMs in W_IDLE / R_IDLE.
  - Log outputs = 0.
- READY/VALID outputs are registered.
- AWREADY/ARREADY rise in the first cycle after ARESETN deasserts.
- Write latency:
  - AW handshake in cycle 0 → WREADY=1 from cycle 1.
  - WLAST handshake in cycle k → BVALID=1 in cycle k+1.
  - B handshake in cycle m → AWREADY=1 in cycle m+1.
- Read latency:
  - AR handshake in cycle 0 → first RVALID in cycle 1.
  - With RREADY held high, the burst takes one beat per cycle.
  - ARREADY=1 the cycle after the RLAST handshake.
- ARESETN asserted mid-transaction:
  - Both FSMs return to idle immediately and all valids/readies clear.
  - The partial transaction is abandoned; the interconnect is reset in the same domain.

## Configuration
- PU_DENY_LOG_EN defined: the log ports exist.
  - DENY_COUNT increments on each AW or AR handshake, saturating at 32'hFFFFFFFF.
  - Simultaneous AW and AR handshakes add 2.
  - LAST_DENY_* update on each handshake; write wins when both occur in one cycle.
  - Outputs are registered and update the cycle after the handshake.
- PU_DENY_LOG_EN undefined: the log ports and logic are absent; the responder behaviour is unchanged.

## Structure
- pu_pkg holds:
  - the w_state_t and r_state_t enums;
  - the DENY_RESP default constant;
  - deny_log_t, a struct of count, addr, id and write.
- Sub-module pu_deny_log, instantiated only under PU_DENY_LOG_EN, implements the saturating counter and the capture registers.

## Test plan
- AWID=0x12, 4 W beats with WLAST on the 4th, BREADY=1 → BVALID in the cycle after the 4th beat, BID=0x12, BRESP=2'b11, exactly 4 WREADY handshakes.
- ARID=0x07, ARLEN=3, RREADY=1 → 4 consecutive R beats, RLAST only on the 4th, RDATA=0, RRESP=2'b11, ARREADY=1 the cycle after.
- ARLEN=0 with RREADY toggling 0/1 → a single beat with RLAST=1, held stable until accepted.
- AW (ID 0x1) and AR (ID 0x2, LEN 1) in the same cycle with BREADY=0 for 5 cycles → R burst completes independently; BVALID held until BREADY, then BID=0x1.
- ARESETN pulsed low mid-read (beat 2 of 8) → all valids 0 at once; ARREADY=1 the first cycle after release; a new AR is served from beat 0.
- PU_DENY_LOG_EN with DENY_COUNT preloaded near saturation by forcing, plus simultaneous AW/AR at AWADDR=0x4000_0000 → count saturates at 0xFFFFFFFF, LAST_DENY_WRITE=1, LAST_DENY_ADDR=0x4000_0000.
